// File: rtl/reg_file.sv
// reg_file: 32 x XLEN integer register file for the single-cycle RISC-V core.
// Two combinational read ports and one write port committed on the rising clk edge.
// x0 has no storage and always reads as zero.
// Optional build macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding
// for the pipelined core variant. Storage, reset and write timing are unchanged by it.
module reg_file #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  // Storage for x1..x(NREG-1). Index 0 is deliberately absent.
  logic [XLEN-1:0] regs [1:NREG-1];

  // One-hot per-register write enables. Index 0 has no enable, so writes to x0 are dropped.
  logic [NREG-1:1] wen;

  // Raw array reads before reset gating and forwarding.
  logic [XLEN-1:0] rd1_raw;
  logic [XLEN-1:0] rd2_raw;

  // Decode the write port into per-register enables.
  always_comb begin
    wen = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      wen[i] = we & (rd == AW'(i));
    end
  end

  // Register array: async clear on reset, otherwise a gated write on the rising edge.
  // The final else is unreachable for 0/1 enables. An unknown enable therefore
  // poisons the target register with X in simulation instead of holding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (wen[i]) begin
          regs[i] <= wdata;
        end else if (!wen[i]) begin
          regs[i] <= regs[i];
        end else begin
          regs[i] <= 'x;
        end
      end
    end
  end

  // Combinational read muxes. Index 0 matches no entry and falls through to zero.
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (rs1 == AW'(i)) rd1_raw = regs[i];
      if (rs2 == AW'(i)) rd2_raw = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  // Forward the in-flight write to a matching read port. x0 never matches.
  always_comb begin
    fwd1   = we && (rd != '0) && (rs1 == rd);
    fwd2   = we && (rd != '0) && (rs2 == rd);
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n) begin
      rdata1 = fwd1 ? wdata : rd1_raw;
      rdata2 = fwd2 ? wdata : rd2_raw;
    end
  end
`else
  // Present the stored values. Reset forces both ports to zero while it is held.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst_n) begin
      rdata1 = rd1_raw;
      rdata2 = rd2_raw;
    end
  end
`endif

  // x0 must read as zero on both ports.
  a_x0_port1: assert property (@(posedge clk) (rs1 == '0) |-> (rdata1 == '0));
  a_x0_port2: assert property (@(posedge clk) (rs2 == '0) |-> (rdata2 == '0));

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default parameters).
module tb_reg_file;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            we;
  logic [XLEN-1:0] wdata;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  int checks;
  int failures;

  reg_file #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .we     (we),
    .wdata  (wdata),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper: present a write at the falling edge, commit it on the next rising edge.
  task automatic write_reg(input logic [AW-1:0] idx, input logic [XLEN-1:0] val);
    @(negedge clk);
    we = 1'b1; rd = idx; wdata = val;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; we = 1'b1; rd = 5'd4; wdata = 32'hCAFEF00D; rs1 = 5'd4; rs2 = 5'd31;
    @(posedge clk); #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=%h", rdata1, 32'h0); end
    checks++;
    if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=%h", rdata2, 32'h0); end
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL reset_write_ignored got=%h exp=%h", rdata1, 32'h0); end
  endtask

  task automatic test_reset_clear;
    write_reg(5'd5, 32'hDEADBEEF);
    rs1 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL preclear_x5 got=%h exp=%h", rdata1, 32'hDEADBEEF); end
    // Mid-cycle reset pulse: no clock edge occurs before the check.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL async_clear_x5 got=%h exp=%h", rdata1, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL after_release_x5 got=%h exp=%h", rdata1, 32'h0); end
  endtask

  task automatic test_basic;
    write_reg(5'd3, 32'h12345678);
    rs1 = 5'd3; rs2 = 5'd3;
    #1;
    checks++;
    if (rdata1 !== 32'h12345678) begin failures++; $display("FAIL basic_rdata1 got=%h exp=%h", rdata1, 32'h12345678); end
    checks++;
    if (rdata2 !== 32'h12345678) begin failures++; $display("FAIL basic_rdata2 got=%h exp=%h", rdata2, 32'h12345678); end
  endtask

  task automatic test_x0;
    @(negedge clk);
    we = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL x0_same_cycle got=%h exp=%h", rdata1, 32'h0); end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL x0_rdata1 got=%h exp=%h", rdata1, 32'h0); end
    checks++;
    if (rdata2 !== 32'h0) begin failures++; $display("FAIL x0_rdata2 got=%h exp=%h", rdata2, 32'h0); end
  endtask

  task automatic test_we_gating;
    write_reg(5'd7, 32'hA5A5A5A5);
    @(negedge clk);
    we = 1'b0; rd = 5'd7; wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rs1 = 5'd7;
    #1;
    checks++;
    if (rdata1 !== 32'hA5A5A5A5) begin failures++; $display("FAIL we_gating_x7 got=%h exp=%h", rdata1, 32'hA5A5A5A5); end
  endtask

  task automatic test_read_during_write;
    logic [XLEN-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    write_reg(5'd9, 32'h11);
    @(negedge clk);
    we = 1'b1; rd = 5'd9; wdata = 32'h22; rs1 = 5'd9; rs2 = 5'd9;
    #1;
    checks++;
    if (rdata1 !== exp_pre) begin failures++; $display("FAIL rdw_pre_rdata1 got=%h exp=%h", rdata1, exp_pre); end
    checks++;
    if (rdata2 !== exp_pre) begin failures++; $display("FAIL rdw_pre_rdata2 got=%h exp=%h", rdata2, exp_pre); end
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    checks++;
    if (rdata1 !== 32'h22) begin failures++; $display("FAIL rdw_post_rdata1 got=%h exp=%h", rdata1, 32'h22); end
  endtask

  task automatic test_back_to_back;
    // Consecutive-cycle writes to neighbouring registers, no idle cycles between them.
    @(negedge clk);
    we = 1'b1; rd = 5'd10; wdata = 32'h0000AAAA;
    @(negedge clk);
    rd = 5'd11; wdata = 32'h0000BBBB;
    @(negedge clk);
    rd = 5'd10; wdata = 32'h0000CCCC;
    @(negedge clk);
    we = 1'b0; rs1 = 5'd10; rs2 = 5'd11;
    #1;
    checks++;
    if (rdata1 !== 32'h0000CCCC) begin failures++; $display("FAIL b2b_x10 got=%h exp=%h", rdata1, 32'h0000CCCC); end
    checks++;
    if (rdata2 !== 32'h0000BBBB) begin failures++; $display("FAIL b2b_x11 got=%h exp=%h", rdata2, 32'h0000BBBB); end
  endtask

  task automatic test_sweep;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
    for (int i = 1; i < 32; i++) begin
      write_reg(AW'(i), 32'(i) * 32'h01010101);
    end
    @(negedge clk);
    for (int i = 1; i < 32; i++) begin
      rs1 = AW'(i);
      rs2 = AW'(32 - i);
      e1 = 32'(i) * 32'h01010101;
      e2 = 32'(32 - i) * 32'h01010101;
      #1;
      checks++;
      if (rdata1 !== e1) begin failures++; $display("FAIL sweep_rs1 idx=%0d got=%h exp=%h", i, rdata1, e1); end
      checks++;
      if (rdata2 !== e2) begin failures++; $display("FAIL sweep_rs2 idx=%0d got=%h exp=%h", 32 - i, rdata2, e2); end
    end
    rs1 = 5'd0; rs2 = 5'd31;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin failures++; $display("FAIL sweep_x0 got=%h exp=%h", rdata1, 32'h0); end
    checks++;
    if (rdata2 !== 32'h1F1F1F1F) begin failures++; $display("FAIL sweep_x31 got=%h exp=%h", rdata2, 32'h1F1F1F1F); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; we = 1'b0; rd = '0; wdata = '0; rs1 = '0; rs2 = '0;
    test_reset;
    test_reset_clear;
    test_basic;
    test_x0;
    test_we_gating;
    test_read_during_write;
    test_back_to_back;
    test_sweep;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
